// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter shared types, register map and constants.
// Build option IRQ_ARB_ROUND_ROBIN_EN selects rotating priority.
package irq_arbiter_pkg;

  localparam int         MAX_SRC   = 8;
  localparam logic [7:0] NO_VECTOR = 8'hFF;

  localparam logic [1:0] OFS_PENDING = 2'd0;
  localparam logic [1:0] OFS_MASK    = 2'd1;
  localparam logic [1:0] OFS_VECTOR  = 2'd2;
  localparam logic [1:0] OFS_COUNT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RAISE,
    HOLD
  } state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter request/ack and bus control signals.
// master = bus/CPU/peripheral side, slave = arbiter.
interface irq_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [7:0]         BUS_ADDR;
  logic               BUS_WE;
  logic [NUM_SRC-1:0] SRC_IRQ;
  logic [NUM_SRC-1:0] SRC_ACK;
  logic               CPU_IRQ;
  logic               CPU_ACK;

  modport master (
    output BUS_ADDR, BUS_WE, SRC_IRQ, CPU_ACK,
    input  SRC_ACK, CPU_IRQ
  );

  modport slave (
    input  BUS_ADDR, BUS_WE, SRC_IRQ, CPU_ACK,
    output SRC_ACK, CPU_IRQ
  );
endinterface

// File: rtl/irq_priority_pick.sv
// Combinational winner search starting at a pointer, wrapping mod NUM_SRC.
// Build option IRQ_ARB_ROUND_ROBIN_EN drives a nonzero pointer.
module irq_priority_pick
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [MAX_SRC-1:0] cand,
  input  logic [2:0]         start,
  output logic [2:0]         idx,
  output logic               valid
);

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int j;
      j = int'(start) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (cand[j]) begin
        idx   = 3'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Bus-mapped interrupt arbiter: edge capture, mask, grant FSM, registers.
// Build option IRQ_ARB_ROUND_ROBIN_EN: rotating priority, pointer in COUNT[7:5].
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic         CLK,
  input  logic         RESET,
  inout  wire  [7:0]   BUS_DATA,
  irq_arbiter_if.slave bus
);

  localparam logic [7:0] SRC_MASK = 8'((1 << NUM_SRC) - 1);
`ifdef IRQ_ARB_ROUND_ROBIN_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 8;
`endif

  state_t             state, state_n;
  logic [NUM_SRC-1:0] irq_sync, irq_prev, src_ack;
  logic [7:0]         pending, pending_n, mask;
  logic [7:0]         rise, ack_clr, w1c;
  logic [7:0]         ofs, rd_mux, rd_q, vector, cnt_rd;
  logic [2:0]         grant, grant_n, ptr, pick_idx;
  logic [CNT_W-1:0]   cnt;
  logic               pick_valid, ack_fire;
  logic               in_win, wr_en, rd_en, rd_vld;

  assign ofs    = bus.BUS_ADDR - BASE_ADDR;
  assign in_win = (ofs[7:2] == 6'd0);
  assign wr_en  = in_win & bus.BUS_WE;
  assign rd_en  = in_win & ~bus.BUS_WE;

  assign w1c = (wr_en && ofs[1:0] == OFS_PENDING)
             ? (BUS_DATA & SRC_MASK) : 8'h00;
  assign rise    = 8'(irq_sync & ~irq_prev);
  assign ack_clr = ack_fire ? (8'h01 << grant) : 8'h00;
  // A fresh edge beats both clear paths in the same cycle.
  assign pending_n = ((pending & ~ack_clr & ~w1c) | rise) & SRC_MASK;
  assign vector = (state == RAISE) ? {5'd0, grant} : NO_VECTOR;

  irq_priority_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .cand  (pending & mask),
    .start (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    ack_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_idx;
          state_n = RAISE;
        end
      end
      RAISE: begin
        // Winner moved or vanished: withdraw without acknowledging.
        if (!pick_valid || pick_idx != grant) begin
          state_n = IDLE;
        end else if (bus.CPU_ACK) begin
          ack_fire = 1'b1;
          state_n  = HOLD;
        end
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      grant    <= 3'd0;
      irq_sync <= '0;
      irq_prev <= '0;
      pending  <= 8'h00;
      mask     <= 8'h00;
      cnt      <= '0;
      src_ack  <= '0;
      rd_q     <= 8'h00;
      rd_vld   <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      irq_sync <= bus.SRC_IRQ;
      irq_prev <= irq_sync;
      pending  <= pending_n;
      if (wr_en && ofs[1:0] == OFS_MASK) mask <= BUS_DATA & SRC_MASK;
      if (ack_fire) cnt <= cnt + 1'b1;
      src_ack  <= ack_clr[NUM_SRC-1:0];
      rd_vld   <= rd_en;
      if (rd_en) rd_q <= rd_mux;
    end
  end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr <= 3'd0;
    end else if (ack_fire) begin
      ptr <= (int'(grant) == NUM_SRC - 1) ? 3'd0 : grant + 3'd1;
    end
  end
  assign cnt_rd = {ptr, cnt};
`else
  assign ptr    = 3'd0;
  assign cnt_rd = cnt;
`endif

  always_comb begin
    rd_mux = 8'h00;
    unique case (ofs[1:0])
      OFS_PENDING: rd_mux = pending;
      OFS_MASK:    rd_mux = mask;
      OFS_VECTOR:  rd_mux = vector;
      OFS_COUNT:   rd_mux = cnt_rd;
    endcase
  end

  assign BUS_DATA    = (rd_vld && rd_en) ? rd_q : 8'hzz;
  assign bus.CPU_IRQ = (state == RAISE);
  assign bus.SRC_ACK = src_ack;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed steps plus random trials.
// Honours IRQ_ARB_ROUND_ROBIN_EN in its reference model.
`timescale 1ns/1ps
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;

  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'hE0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic       drv   = 1'b0;
  logic [7:0] wdata = 8'h00;
  wire  [7:0] BUS_DATA;

  int         n_chk    = 0;
  int         n_fail   = 0;
  logic [7:0] m_pend   = 8'h00;
  logic [7:0] m_mask   = 8'h00;
  int         m_ptr    = 0;
  int         m_grants = 0;

  irq_arbiter_if #(.NUM_SRC(N)) bus ();

  irq_arbiter #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS_DATA (BUS_DATA),
    .bus      (bus)
  );

  assign BUS_DATA = drv ? wdata : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (BUS_DATA[g]);
  end

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] c, input int p);
    for (int k = 0; k < N; k++) begin
      if (c[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_count();
    if (RR) return {3'(m_ptr), 5'(m_grants)};
    return 8'(m_grants);
  endfunction

  task automatic do_reset();
    RESET = 1'b0;
    bus.CPU_ACK  = 1'b0;
    bus.SRC_IRQ  = '0;
    bus.BUS_WE   = 1'b0;
    bus.BUS_ADDR = 8'h00;
    drv = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_ptr = 0;
    m_grants = 0;
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d);
    bus.BUS_ADDR = BASE + 8'(o);
    bus.BUS_WE = 1'b1;
    wdata = d;
    drv = 1'b1;
    tick();
    bus.BUS_WE = 1'b0;
    drv = 1'b0;
    bus.BUS_ADDR = 8'h00;
    if (o == OFS_MASK) m_mask = d & 8'h0F;
    if (o == OFS_PENDING) m_pend = m_pend & ~d;
  endtask

  task automatic rd(input logic [1:0] o, output logic [7:0] d);
    bus.BUS_ADDR = BASE + 8'(o);
    bus.BUS_WE = 1'b0;
    tick();
    d = BUS_DATA;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] o,
                        input logic [7:0] exp);
    logic [7:0] d;
    rd(o, d);
    chk(tag, d, exp);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    bus.SRC_IRQ = m;
    tick();
    bus.SRC_IRQ = '0;
    m_pend = m_pend | 8'(m);
  endtask

  task automatic service(input string tag);
    int         w;
    logic [7:0] v;
    bit         ok;
    w = pick(m_pend & m_mask, m_ptr);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.CPU_IRQ === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_irq"}, 8'(ok), 8'h01);
    rd(OFS_VECTOR, v);
    chk({tag, "_vec"}, v, 8'(w));
    bus.CPU_ACK = 1'b1;
    tick();
    bus.CPU_ACK = 1'b0;
    chk({tag, "_ack"}, 8'(bus.SRC_ACK), 8'h01 << w);
    chk({tag, "_drop"}, 8'(bus.CPU_IRQ), 8'h00);
    tick();
    chk({tag, "_ack1"}, 8'(bus.SRC_ACK), 8'h00);
    m_pend = m_pend & ~(8'h01 << w);
    m_grants++;
    if (RR) m_ptr = (w + 1) % N;
  endtask

  initial begin
    bus.BUS_ADDR = 8'h00;
    bus.BUS_WE   = 1'b0;
    bus.SRC_IRQ  = '0;
    bus.CPU_ACK  = 1'b0;

    // reset state
    tick();
    chk("rst_irq", 8'(bus.CPU_IRQ), 8'h00);
    chk("rst_ack", 8'(bus.SRC_ACK), 8'h00);
    chk("rst_z", BUS_DATA, 8'hFF);
    RESET = 1'b1;
    tick();
    chk_rd("rst_vec", OFS_VECTOR, NO_VECTOR);
    chk_rd("rst_mask", OFS_MASK, 8'h00);
    chk_rd("rst_cnt", OFS_COUNT, 8'h00);
    chk_rd("rst_pend", OFS_PENDING, 8'h00);

    // single source, latency and upper-bit masking
    wr(OFS_MASK, 8'hFF);
    chk_rd("mask_rd", OFS_MASK, m_mask);
    pulse(4'b0100);
    chk("lat1", 8'(bus.CPU_IRQ), 8'h00);
    tick();
    chk("lat2", 8'(bus.CPU_IRQ), 8'h00);
    tick();
    chk("lat3", 8'(bus.CPU_IRQ), 8'h01);
    service("s2");
    chk_rd("s2_pend", OFS_PENDING, 8'h00);
    chk_rd("s2_cnt", OFS_COUNT, exp_count());

    // reset asserted while in RAISE
    pulse(4'b0001);
    tick();
    tick();
    chk("mr_irq", 8'(bus.CPU_IRQ), 8'h01);
    bus.BUS_ADDR = BASE + 8'(OFS_MASK);
    tick();
    chk("mr_drv", BUS_DATA, 8'h0F);
    RESET = 1'b0;
    #1;
    chk("mr_irq0", 8'(bus.CPU_IRQ), 8'h00);
    chk("mr_z", BUS_DATA, 8'hFF);
    tick();
    chk("mr_z1", BUS_DATA, 8'hFF);
    bus.BUS_ADDR = 8'h00;
    RESET = 1'b1;
    tick();
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_ptr = 0;
    m_grants = 0;
    chk_rd("mr_vec", OFS_VECTOR, NO_VECTOR);
    chk_rd("mr_mask", OFS_MASK, 8'h00);

    // two simultaneous sources, order from model
    wr(OFS_MASK, 8'h0F);
    pulse(4'b0010);
    service("pre");
    pulse(4'b1010);
    service("pa");
    service("pb");
    chk_rd("pr_cnt", OFS_COUNT, exp_count());
    chk_rd("pr_pend", OFS_PENDING, 8'h00);

    // masked request, unmask, withdraw by software clear
    do_reset();
    pulse(4'b0001);
    tick();
    tick();
    tick();
    chk("mg_irq0", 8'(bus.CPU_IRQ), 8'h00);
    chk_rd("mg_pend", OFS_PENDING, 8'h01);
    wr(OFS_MASK, 8'h01);
    tick();
    chk("mg_irq1", 8'(bus.CPU_IRQ), 8'h01);
    wr(OFS_PENDING, 8'h01);
    chk("mg_src0", 8'(bus.SRC_ACK), 8'h00);
    tick();
    chk("mg_irq2", 8'(bus.CPU_IRQ), 8'h00);
    chk("mg_src1", 8'(bus.SRC_ACK), 8'h00);
    chk_rd("mg_vec", OFS_VECTOR, NO_VECTOR);
    chk_rd("mg_cnt", OFS_COUNT, exp_count());

    // edge coinciding with W1C
    wr(OFS_MASK, 8'h00);
    pulse(4'b0001);
    tick();
    tick();
    bus.SRC_IRQ = 4'b0001;
    tick();
    bus.SRC_IRQ = '0;
    wr(OFS_PENDING, 8'h01);
    m_pend = m_pend | 8'h01;
    chk_rd("w1c_set", OFS_PENDING, m_pend);
    wr(OFS_PENDING, 8'h01);
    chk_rd("w1c_clr", OFS_PENDING, m_pend);

    // edge coinciding with ACK clear
    wr(OFS_MASK, 8'h0F);
    pulse(4'b0010);
    tick();
    tick();
    chk("ae_irq", 8'(bus.CPU_IRQ), 8'h01);
    bus.SRC_IRQ = 4'b0010;
    tick();
    bus.SRC_IRQ = '0;
    bus.CPU_ACK = 1'b1;
    tick();
    bus.CPU_ACK = 1'b0;
    chk("ae_ack", 8'(bus.SRC_ACK), 8'h02);
    m_grants++;
    if (RR) m_ptr = 2;
    chk_rd("ae_pend", OFS_PENDING, m_pend);
    service("ae2");
    chk_rd("ae_cnt", OFS_COUNT, exp_count());

    // 256 grants: counter wrap
    do_reset();
    wr(OFS_MASK, 8'h01);
    for (int i = 0; i < 256; i++) begin
      pulse(4'b0001);
      service("wrap");
    end
    chk_rd("wrap_cnt", OFS_COUNT, exp_count());

    // random masks and request sets
    do_reset();
    for (int t = 0; t < 24; t++) begin
      logic [7:0]   mk;
      logic [N-1:0] ev;
      mk = 8'($urandom_range(0, 15));
      ev = N'($urandom_range(1, 15));
      wr(OFS_MASK, mk);
      pulse(ev);
      tick();
      tick();
      while (pick(m_pend & m_mask, m_ptr) >= 0) service("rnd");
      tick();
      tick();
      chk("rnd_idle", 8'(bus.CPU_IRQ), 8'h00);
      chk_rd("rnd_pend", OFS_PENDING, m_pend);
      chk_rd("rnd_cnt", OFS_COUNT, exp_count());
      wr(OFS_PENDING, m_pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Bus-mapped interrupt arbiter between the peripherals (timer, mouse, seven-segment, future IO) and one processor interrupt line. It latches up to eight peripheral requests, applies a software mask, selects one winner and holds it until the processor acknowledges. It then returns a single-cycle acknowledge to the winning source. Software reads the winner's identity from a vector register on the shared 8-bit data/address bus.

## Interface
- NUM_SRC, 4, number of request sources, 1..8
- BASE_ADDR, 8'hE0, base of the 4-byte register window (BASE_ADDR..BASE_ADDR+3)
- CLK  in  1  system clock, all logic rising-edge
- RESET  in  1  asynchronous, active-low reset; one clock domain only
- BUS_DATA  inout  8  shared data bus; driven only during reads of the window, else high-Z
- BUS_ADDR  in  8  shared address bus
- BUS_WE  in  1  bus write strobe, 1 = write
- SRC_IRQ  in  NUM_SRC  peripheral requests; rising edge = event
- SRC_ACK  out  NUM_SRC  one-cycle acknowledge pulse to the serviced source
- CPU_IRQ  out  1  to processor interrupt-raise input
- CPU_ACK  in  1  processor interrupt acknowledge; treated as a level, sampled each cycle

## Operation
- Registers (offset):
  - +0 PENDING: read pending bits; write-1-to-clear.
  - +1 MASK: read/write; bit=1 enables the source. Reset 8'h00.
  - +2 VECTOR: read only; index of the current grant, 8'hFF if none.
  - +3 COUNT: read only; 8-bit count of grants issued, wraps at 8'hFF->8'h00.
  - Bits >= NUM_SRC read 0; writes to them are ignored.
- Edge capture: SRC_IRQ is registered once; a 0->1 transition sets pending[i].
- Arbitration: the candidate set is pending & MASK. Fixed priority: the lowest index wins.
- FSM states:
  - IDLE: when the candidate set is non-empty, latch grant, go to RAISE.
  - RAISE: CPU_IRQ=1, VECTOR=grant. On CPU_ACK=1, pulse SRC_ACK[grant], clear pending[grant], increment COUNT, go to HOLD.
  - HOLD: CPU_IRQ=0 for one cycle while CPU_ACK settles, then go to IDLE.
- Grant is frozen in RAISE. Any of these returns the FSM to IDLE without an ACK pulse and sets VECTOR to 8'hFF:
  - a higher-priority arrival (grant does not change),
  - a mask change that removes the grant,
  - a software clear of pending[grant].
- Simultaneous events on one bit in one cycle:
  - new edge together with ACK-clear: set wins, pending stays 1.
  - new edge together with W1C: set wins.
- Reset: all registers, pending, FSM=IDLE, COUNT=0. CPU_IRQ=0, SRC_ACK=0, VECTOR=8'hFF, BUS_DATA=Z.

## Timing
- SRC_IRQ edge at cycle n: pending set at n+2 (sync stage + edge register). CPU_IRQ=1 at n+3 if unmasked and the FSM is IDLE.
- CPU_ACK high in cycle m (in RAISE): SRC_ACK[grant]=1 in cycle m+1 only. CPU_IRQ=0 from m+1. Earliest next CPU_IRQ at m+3.
- Bus read: data is registered. It is valid on BUS_DATA the cycle after the address is presented with BUS_WE=0 and stays driven while the address remains in the window.
- Bus write: takes effect at the clock edge where BUS_WE=1 and the address is in the window.
- CPU_ACK outside RAISE is ignored.

## Configuration
- IRQ_ARB_ROUND_ROBIN_EN defined: rotating priority. A pointer starts at 0; search is from the pointer upward, modulo NUM_SRC. After each ACK the pointer = (grant+1) mod NUM_SRC. The pointer resets to 0 and is readable in COUNT[7:5]; COUNT[4:0] then counts grants and wraps at 31.
- Undefined: fixed lowest-index priority. COUNT is a full 8-bit counter.

## Structure
- Package irq_arbiter_pkg holds:
  - register offsets OFS_PENDING/OFS_MASK/OFS_VECTOR/OFS_COUNT
  - FSM state enum (IDLE, RAISE, HOLD)
  - NO_VECTOR = 8'hFF
  - MAX_SRC = 8
- One sub-module, irq_priority_pick: combinational winner and valid from the candidate vector plus start pointer. The pointer is tied to 0 when IRQ_ARB_ROUND_ROBIN_EN is absent.

## Test plan
- Reset low mid-RAISE -> CPU_IRQ=0, VECTOR reads 8'hFF, MASK reads 8'h00, BUS_DATA high-Z next cycle.
- MASK=8'h0F, edge on SRC_IRQ[2] -> CPU_IRQ at +3 cycles, VECTOR=8'h02. CPU_ACK pulse -> SRC_ACK=4'b0100 for exactly one cycle, PENDING=0, COUNT=1.
- Edges on SRC_IRQ[3] and [1] in the same cycle, fixed priority:
  - grants in order 1 then 3, two SRC_ACK pulses, COUNT=2.
  - with IRQ_ARB_ROUND_ROBIN_EN and pointer=2: order 3 then 1.
- MASK=0, edge on SRC_IRQ[0] -> PENDING=8'h01, CPU_IRQ stays 0. Write MASK=8'h01 -> CPU_IRQ rises. Write PENDING=8'h01 while in RAISE -> CPU_IRQ drops, no SRC_ACK, VECTOR=8'hFF.
- New SRC_IRQ[1] edge landing in the same cycle as its ACK-clear -> PENDING[1] remains 1 and a second grant follows.
- 256 serviced grants (fixed priority) -> COUNT wraps to 8'h00.
